vga_sync_timing: RTL and testbench
==================================

VGA_SYNC_TIMING -- requirements
Module: vga_sync_timing

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Parameter SYNC_ACTIVE, 1'b0, active level of hsync and vsync; the inactive level is ~SYNC_ACTIVE.
REQ-010 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-011 Port reset, input, 1, reset, synchronous, active-high.
REQ-012 Port tick_in, input, 1, pixel-rate square wave from the upstream tick generator, synchronous to clk.
REQ-013 Port hsync, output, 1, horizontal sync.
REQ-014 Port vsync, output, 1, vertical sync.
REQ-015 Port video_on, output, 1, high when the current position is inside the visible area.
REQ-016 Port pixel_x, output, 10, current horizontal count.
REQ-017 Port pixel_y, output, 10, current vertical count.
REQ-018 Port line_end, output, 1, one-clk pulse on horizontal wrap.
REQ-019 Port frame_start, output, 1, one-clk pulse on wrap to (0,0).

Function
REQ-020 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK; both SHALL be <= 1024, with out-of-range values unsupported.
REQ-021 A one-bit register tick_q SHALL hold tick_in sampled at the previous clk edge; advance = tick_in & ~tick_q.
REQ-022 The horizontal and vertical counters SHALL change only on a clk edge where advance=1; one tick_in high phase of any length SHALL produce exactly one advance.
REQ-023 On advance, h_count SHALL increment, and when h_count = H_TOTAL-1 it SHALL instead wrap to 0.
REQ-024 On advance with h wrap, v_count SHALL increment, and when v_count = V_TOTAL-1 it SHALL instead wrap to 0; v_count is unchanged when h does not wrap.
REQ-025 pixel_x/pixel_y SHALL equal h_count/v_count, updated on the same edge as the counters, with zero added latency.
REQ-026 hsync SHALL equal SYNC_ACTIVE iff H_DISPLAY+H_FRONT <= h_count <= H_DISPLAY+H_FRONT+H_SYNC-1.
REQ-027 vsync SHALL equal SYNC_ACTIVE iff V_DISPLAY+V_FRONT <= v_count <= V_DISPLAY+V_FRONT+V_SYNC-1.
REQ-028 video_on SHALL be 1 iff h_count < H_DISPLAY and v_count < V_DISPLAY.
REQ-029 hsync, vsync and video_on SHALL be registered outputs, always consistent with pixel_x/pixel_y in the same cycle, with no combinational path from tick_in.
REQ-030 line_end SHALL be 1 for exactly the one clk following an advance that wrapped h_count, and 0 otherwise.
REQ-031 frame_start SHALL be 1 for exactly the one clk following an advance that wrapped both counters to (0,0), and 0 otherwise; when it is 1, line_end is also 1.
REQ-032 tick_in held constant (high or low) SHALL freeze all counters and sync outputs; pulses are 0.

Reset
REQ-033 While reset=1 at a clk edge, the block SHALL load h_count=H_TOTAL-1, v_count=V_TOTAL-1, tick_q=0.
REQ-034 Under reset it SHALL set pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1, hsync=vsync=~SYNC_ACTIVE, video_on=0, line_end=0, frame_start=0, regardless of tick_in.
REQ-035 Reset SHALL take priority over advance on the same edge, and mid-frame reset SHALL abandon the current position immediately.
REQ-036 The first advance after reset SHALL move to (0,0) with line_end=frame_start=1 and video_on=1.

Verification
REQ-037 Hold reset 3 clks with tick_in toggling every clk -> outputs stay at (799,524), hsync=vsync=1, video_on=0, pulses 0.
REQ-038 After reset, drive tick_in high 2 clks / low 2 clks -> pixel_x steps 0,1,2,... once per 4 clks, with no double count while tick_in is held high.
REQ-039 Apply advances 1..657 after reset -> hsync=0 first at pixel_x=656 and back to 1 at pixel_x=752; video_on=0 from pixel_x=640.
REQ-040 Apply 801 advances -> pixel_x 799->0, pixel_y 0->1, line_end high exactly 1 clk, frame_start stays 0.
REQ-041 Apply 420001 advances -> return to (0,0) with frame_start pulse; vsync=0 only on lines 490-491.
REQ-042 Assert reset at (300,200) mid-line -> next clk outputs at reset values; the first advance after release gives (0,0), frame_start=1.

Source files
------------

// File: rtl/vga_sync_timing_if.sv
// Pixel-timing bundle between the sync generator and its consumer.
// The generator (master) samples tick_in and drives the timing outputs.
// The consumer (slave) supplies tick_in and observes the timing.
interface vga_sync_timing_if;
   logic       tick_in;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       line_end;
   logic       frame_start;

   modport master (
      input  tick_in,
      output hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_start
   );

   modport slave (
      output tick_in,
      input  hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_start
   );
endinterface

// File: rtl/vga_sync_timing.sv
// VGA horizontal/vertical timing generator.
// The counters advance once per rising edge of the pixel tick. The next
// position is decoded combinationally, and every output is taken from a
// register, so sync and blanking always match pixel_x/pixel_y in the same
// cycle. Reset parks the position on the last pixel of the frame, so the
// first advance lands on (0,0) and raises line_end and frame_start.
module vga_sync_timing #(
   parameter int   H_DISPLAY   = 640,
   parameter int   H_FRONT     = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BACK      = 48,
   parameter int   V_DISPLAY   = 480,
   parameter int   V_FRONT     = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BACK      = 33,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   vga_sync_timing_if.master vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
   // Decode limits are one bit wider so a 1024-wide region still compares correctly.
   localparam logic [10:0] H_VIS_END = 11'(H_DISPLAY);
   localparam logic [10:0] V_VIS_END = 11'(V_DISPLAY);
   localparam logic [10:0] H_SYNC_LO = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] H_SYNC_HI = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [10:0] V_SYNC_LO = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] V_SYNC_HI = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic       tick_q_r;
   logic [9:0] h_count_r;
   logic [9:0] v_count_r;
   logic       hsync_r;
   logic       vsync_r;
   logic       video_on_r;
   logic       line_end_r;
   logic       frame_start_r;

   logic       advance_s;
   logic [9:0] h_next_s;
   logic [9:0] v_next_s;
   logic       h_wrap_s;
   logic       v_wrap_s;
   logic       hsync_next_s;
   logic       vsync_next_s;
   logic       video_on_next_s;

   // Find the tick rising edge and the position that follows it.
   always_comb begin
      advance_s = vga.tick_in & ~tick_q_r;
      h_next_s  = h_count_r;
      v_next_s  = v_count_r;
      h_wrap_s  = 1'b0;
      v_wrap_s  = 1'b0;
      if (advance_s) begin
         if (h_count_r == H_LAST) begin
            h_next_s = 10'd0;
            h_wrap_s = 1'b1;
            if (v_count_r == V_LAST) begin
               v_next_s = 10'd0;
               v_wrap_s = 1'b1;
            end else begin
               v_next_s = v_count_r + 10'd1;
            end
         end else begin
            h_next_s = h_count_r + 10'd1;
         end
      end else begin
         h_next_s = h_count_r;
      end
   end

   // Decode sync and visible area from the next position, so they are registered alongside it.
   always_comb begin
      hsync_next_s    = ~SYNC_ACTIVE;
      vsync_next_s    = ~SYNC_ACTIVE;
      video_on_next_s = 1'b0;
      if (({1'b0, h_next_s} >= H_SYNC_LO) && ({1'b0, h_next_s} <= H_SYNC_HI)) begin
         hsync_next_s = SYNC_ACTIVE;
      end else begin
         hsync_next_s = ~SYNC_ACTIVE;
      end
      if (({1'b0, v_next_s} >= V_SYNC_LO) && ({1'b0, v_next_s} <= V_SYNC_HI)) begin
         vsync_next_s = SYNC_ACTIVE;
      end else begin
         vsync_next_s = ~SYNC_ACTIVE;
      end
      if (({1'b0, h_next_s} < H_VIS_END) && ({1'b0, v_next_s} < V_VIS_END)) begin
         video_on_next_s = 1'b1;
      end else begin
         video_on_next_s = 1'b0;
      end
   end

   // Position, tick history and all outputs; reset overrides any advance on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q_r      <= 1'b0;
         h_count_r     <= H_LAST;
         v_count_r     <= V_LAST;
         hsync_r       <= ~SYNC_ACTIVE;
         vsync_r       <= ~SYNC_ACTIVE;
         video_on_r    <= 1'b0;
         line_end_r    <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         tick_q_r      <= vga.tick_in;
         h_count_r     <= h_next_s;
         v_count_r     <= v_next_s;
         hsync_r       <= hsync_next_s;
         vsync_r       <= vsync_next_s;
         video_on_r    <= video_on_next_s;
         line_end_r    <= h_wrap_s;
         frame_start_r <= h_wrap_s & v_wrap_s;
      end
   end

   assign vga.hsync       = hsync_r;
   assign vga.vsync       = vsync_r;
   assign vga.video_on    = video_on_r;
   assign vga.pixel_x     = h_count_r;
   assign vga.pixel_y     = v_count_r;
   assign vga.line_end    = line_end_r;
   assign vga.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing: a default 640x480 instance and a small,
// positive-sync instance share the same tick/reset stimulus. The reference
// model counts advances since reset and maps that count to a frame position
// with plain division and modulo arithmetic.
module tb_vga_sync_timing;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   longint n_adv = 0;
   bit   prev_t = 1'b0;
   bit   last_adv = 1'b0;

   vga_sync_timing_if d_if ();
   vga_sync_timing_if s_if ();

   vga_sync_timing dut_d (.clk(clk), .reset(reset), .vga(d_if.master));

   vga_sync_timing #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
      .SYNC_ACTIVE(1'b1)
   ) dut_s (.clk(clk), .reset(reset), .vga(s_if.master));

   always #5 clk = ~clk;

   typedef struct {
      logic        t;
      logic        r;
      logic [24:0] exp;
   } vec_t;

   vec_t tbl[12];

   // Packed layout: {hsync, vsync, video_on, line_end, frame_start, x[9:0], y[9:0]}
   function automatic logic [24:0] mk(logic hs, logic vs, logic von, logic le, logic fs,
                                      int x, int y);
      return {hs, vs, von, le, fs, 10'(x), 10'(y)};
   endfunction

   function automatic logic [24:0] exp_vec(longint n, bit adv, int hd, int hf, int hsw, int hb,
                                           int vd, int vf, int vsw, int vb, logic sa);
      int ht;
      int vt;
      longint p;
      int x;
      int y;
      logic hs;
      logic vs;
      logic von;
      logic le;
      logic fs;
      ht = hd + hf + hsw + hb;
      vt = vd + vf + vsw + vb;
      if (n == 0) begin
         return mk(~sa, ~sa, 1'b0, 1'b0, 1'b0, ht - 1, vt - 1);
      end
      p   = (n - 1) % (ht * vt);
      x   = int'(p % ht);
      y   = int'(p / ht);
      hs  = (x >= hd + hf && x < hd + hf + hsw) ? sa : ~sa;
      vs  = (y >= vd + vf && y < vd + vf + vsw) ? sa : ~sa;
      von = (x < hd && y < vd);
      le  = adv && (x == 0);
      fs  = adv && (p == 0);
      return mk(hs, vs, von, le, fs, x, y);
   endfunction

   function automatic logic [24:0] act_d();
      return {d_if.hsync, d_if.vsync, d_if.video_on, d_if.line_end, d_if.frame_start,
              d_if.pixel_x, d_if.pixel_y};
   endfunction

   function automatic logic [24:0] act_s();
      return {s_if.hsync, s_if.vsync, s_if.video_on, s_if.line_end, s_if.frame_start,
              s_if.pixel_x, s_if.pixel_y};
   endfunction

   task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 30)
            $display("FAIL %s at adv %0d: got x=%0d y=%0d hs,vs,von,le,fs=%b required x=%0d y=%0d hs,vs,von,le,fs=%b",
                     name, n_adv, act[19:10], act[9:0], act[24:20], exp[19:10], exp[9:0], exp[24:20]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // One clock: drive inputs, step the model on the edge, compare both instances after it.
   task automatic cycle(input logic t, input logic r);
      d_if.tick_in = t;
      s_if.tick_in = t;
      reset        = r;
      @(posedge clk);
      if (r) begin
         n_adv    = 0;
         last_adv = 1'b0;
         prev_t   = 1'b0;
      end else begin
         last_adv = t && !prev_t;
         if (last_adv) n_adv++;
         prev_t = t;
      end
      #1;
      check("dflt", act_d(), exp_vec(n_adv, last_adv, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      check("small", act_s(), exp_vec(n_adv, last_adv, 8, 2, 3, 2, 4, 2, 2, 1, 1'b1));
   endtask

   initial begin
      int hs_low_x;
      int hs_high_x;
      int von_off_x;
      int le_cnt;
      int fs_cnt;
      int vs_min;
      int vs_max;
      logic lvl;
      int len;
      bit rst_now;

      d_if.tick_in = 1'b0;
      s_if.tick_in = 1'b0;
      reset        = 1'b1;

      // Reset with toggling tick, then 2-high/2-low pacing on the default instance.
      tbl[0]  = '{1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 799, 524)};
      tbl[1]  = '{1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 799, 524)};
      tbl[2]  = '{1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 799, 524)};
      tbl[3]  = '{1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0)};
      tbl[4]  = '{1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0)};
      tbl[5]  = '{1'b0, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0)};
      tbl[6]  = '{1'b0, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0)};
      tbl[7]  = '{1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0)};
      tbl[8]  = '{1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0)};
      tbl[9]  = '{1'b0, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0)};
      tbl[10] = '{1'b0, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0)};
      tbl[11] = '{1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0)};

      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].t, tbl[i].r);
         check($sformatf("tbl%0d", i), act_d(), tbl[i].exp);
      end

      // First line of the default instance: sync window, blanking, single wrap pulse.
      cycle(1'b0, 1'b1);
      hs_low_x  = -1;
      hs_high_x = -1;
      von_off_x = -1;
      le_cnt    = 0;
      fs_cnt    = 0;
      for (int i = 1; i <= 801; i++) begin
         cycle(1'b1, 1'b0);
         if (hs_low_x < 0 && d_if.hsync == 1'b0) hs_low_x = int'(d_if.pixel_x);
         if (hs_low_x >= 0 && hs_high_x < 0 && d_if.hsync == 1'b1) hs_high_x = int'(d_if.pixel_x);
         if (von_off_x < 0 && d_if.video_on == 1'b0) von_off_x = int'(d_if.pixel_x);
         if (i > 1) begin
            le_cnt += int'(d_if.line_end);
            fs_cnt += int'(d_if.frame_start);
         end
         cycle(1'b0, 1'b0);
         le_cnt += int'(d_if.line_end);
         fs_cnt += int'(d_if.frame_start);
      end
      check_int("hsync_low_x", hs_low_x, 656);
      check_int("hsync_high_x", hs_high_x, 752);
      check_int("video_off_x", von_off_x, 640);
      check_int("line_end_count", le_cnt, 1);
      check_int("frame_start_count", fs_cnt, 0);
      check_int("wrap_x", int'(d_if.pixel_x), 0);
      check_int("wrap_y", int'(d_if.pixel_y), 1);

      // Two full frames plus one advance on the small instance.
      cycle(1'b0, 1'b1);
      fs_cnt = 0;
      vs_min = 1000;
      vs_max = -1;
      for (int i = 1; i <= 271; i++) begin
         cycle(1'b1, 1'b0);
         fs_cnt += int'(s_if.frame_start);
         if (s_if.frame_start == 1'b1) check_int("fs_implies_le", int'(s_if.line_end), 1);
         if (s_if.vsync == 1'b1) begin
            if (int'(s_if.pixel_y) < vs_min) vs_min = int'(s_if.pixel_y);
            if (int'(s_if.pixel_y) > vs_max) vs_max = int'(s_if.pixel_y);
         end
         cycle(1'b0, 1'b0);
      end
      check_int("small_fs_count", fs_cnt, 3);
      check_int("small_vsync_first_line", vs_min, 6);
      check_int("small_vsync_last_line", vs_max, 7);
      check_int("small_end_x", int'(s_if.pixel_x), 0);
      check_int("small_end_y", int'(s_if.pixel_y), 0);

      // Mid-line reset at x=300 with a tick edge on the same clock.
      cycle(1'b0, 1'b1);
      for (int i = 1; i <= 301; i++) begin
         cycle(1'b1, 1'b0);
         cycle(1'b0, 1'b0);
      end
      check_int("pre_reset_x", int'(d_if.pixel_x), 300);
      cycle(1'b1, 1'b1);
      check_int("reset_x", int'(d_if.pixel_x), 799);
      check_int("reset_y", int'(d_if.pixel_y), 524);
      cycle(1'b1, 1'b0);
      check_int("post_reset_fs", int'(d_if.frame_start), 1);
      check_int("post_reset_x", int'(d_if.pixel_x), 0);

      // Random tick runs of varying length with occasional resets.
      for (int k = 0; k < 1500; k++) begin
         lvl     = 1'($urandom_range(0, 1));
         len     = int'($urandom_range(1, 4));
         rst_now = ($urandom_range(0, 299) == 0);
         for (int j = 0; j < len; j++) begin
            cycle(lvl, rst_now && (j == 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
